// File: rtl/core_coproc_exec_if.sv
// Coprocessor register bus: one request at a time, accepted by ready with
// read data and error returned in the same cycle.
interface core_coproc_exec_if;
    logic        valid;
    logic        write;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        error;

    modport master (
        output valid, write, addr, wdata,
        input  ready, rdata, error
    );

    modport slave (
        input  valid, write, addr, wdata,
        output ready, rdata, error
    );
endinterface

// File: rtl/core_coproc_exec.sv
// Execute stage for MCR/MRC: runs one coprocessor bus transfer per issue,
// stalls the core meanwhile and reports writeback, flag update or undefined trap.
module core_coproc_exec #(
    parameter int CP_NUM  = 15,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  cp_num,
    input  logic [3:0]  crn,
    input  logic [3:0]  crm,
    input  logic [2:0]  op1,
    input  logic [2:0]  op2,
    input  logic        load,
    input  logic [3:0]  rd,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        undefined,
    output logic [3:0]  rd_out,
    output logic        writeback,
    output logic        update_flags,
    output logic [31:0] result,
    output logic [3:0]  flags,
    core_coproc_exec_if.master bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          load_reg;
    logic          squash_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          undefined_reg;
    logic          writeback_reg;
    logic          update_flags_reg;
    logic [3:0]    rd_out_reg;
    logic [31:0]   result_reg;
    logic          valid_reg;
    logic          write_reg;
    logic [13:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic          squash_next;

    // A flush seen in the acceptance cycle itself must still squash the completion.
    assign squash_next = squash_reg | flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            load_reg         <= 1'b0;
            squash_reg       <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            undefined_reg    <= 1'b0;
            writeback_reg    <= 1'b0;
            update_flags_reg <= 1'b0;
            rd_out_reg       <= '0;
            result_reg       <= '0;
            valid_reg        <= 1'b0;
            write_reg        <= 1'b0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg         <= 1'b0;
                    undefined_reg    <= 1'b0;
                    writeback_reg    <= 1'b0;
                    update_flags_reg <= 1'b0;
                    squash_reg       <= 1'b0;
                    if (start && !flush) begin
                        load_reg   <= load;
                        rd_out_reg <= rd;
                        write_reg  <= ~load;
                        addr_reg   <= {op1, crn, crm, op2};
                        wdata_reg  <= wdata;
                        cnt_reg    <= '0;
                        if (cp_num != 4'(CP_NUM)) begin
                            state_reg     <= DONE;
                            done_reg      <= 1'b1;
                            undefined_reg <= 1'b1;
                        end else begin
                            state_reg <= REQ;
                            valid_reg <= 1'b1;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    squash_reg <= squash_next;
                    if (bus.ready) begin
                        state_reg        <= DONE;
                        valid_reg        <= 1'b0;
                        busy_reg         <= 1'b0;
                        if (load_reg)
                            result_reg <= bus.rdata;
                        done_reg         <= ~squash_next;
                        undefined_reg    <= bus.error & ~squash_next;
                        writeback_reg    <= load_reg & (rd_out_reg != 4'd15) & ~bus.error & ~squash_next;
                        update_flags_reg <= load_reg & (rd_out_reg == 4'd15) & ~bus.error & ~squash_next;
                    end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                        state_reg     <= DONE;
                        valid_reg     <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= ~squash_next;
                        undefined_reg <= ~squash_next;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg        <= IDLE;
                    done_reg         <= 1'b0;
                    undefined_reg    <= 1'b0;
                    writeback_reg    <= 1'b0;
                    update_flags_reg <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy         = busy_reg;
    assign done         = done_reg;
    assign undefined    = undefined_reg;
    assign writeback    = writeback_reg;
    assign update_flags = update_flags_reg;
    assign rd_out       = rd_out_reg;
    assign result       = result_reg;
    assign bus.valid    = valid_reg;
    assign bus.write    = write_reg;
    assign bus.addr     = addr_reg;
    assign bus.wdata    = wdata_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_flags
            assign flags[gi] = result_reg[28 + gi];
        end
    endgenerate
endmodule
